// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and helpers for the SRAM subordinate.
// Transfer/size encodings, response codes and byte-lane decode.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        BYTE = 3'd0,
        HALF = 3'd1,
        WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    function automatic logic [3:0] lane_mask(
        input logic [1:0] addr,
        input logic [2:0] size
    );
        logic [3:0] m;
        case (size)
            BYTE:    m = 4'b0001 << addr;
            HALF:    m = addr[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Flop-array word memory: byte-enable write, asynchronous read.
// Contents are deliberately not reset.
module ahb_sram_array #(
    parameter int MemBytes = 4096
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [3:0]                    be,
    input  logic [$clog2(MemBytes)-3:0]   addr,
    input  logic [31:0]                   wdata,
    output logic [31:0]                   rdata
);

    localparam int Words = MemBytes / 4;

    logic [31:0] mem [Words];

    // Byte-lane write of the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate over a flop-array SRAM, with wait states.
// Optional: AHB_SRAM_WRITE_PROTECT_EN makes addr < RomBytes read-only.
module ahb_sram_subordinate
    import ahb_pkg::*;
#(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32,
    parameter int MemBytes     = 4096,
    parameter int WaitStates   = 0
`ifdef AHB_SRAM_WRITE_PROTECT_EN
    ,
    parameter int RomBytes     = 1024
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hsel,
    input  logic [AddressWidth-1:0] haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic [DataWidth-1:0]    hwdata,
    input  logic                    hready,
    output logic [DataWidth-1:0]    hrdata,
    output logic                    hresp,
    output logic                    hreadyout
);

    localparam int AW = $clog2(MemBytes);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_OKAY_DONE,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [AW-1:0]        addr_q;
    logic                 write_q;
    logic [2:0]           size_q;
    logic [DataWidth-1:0] hrdata_q;
    logic [31:0]          rdata;
    logic                 load;
    logic                 bad;
    logic                 we;
    logic                 rd_done;
    logic                 unused;

    assign unused = ^{hburst, htrans[0]};

    // Legality of the address phase currently on the bus
    always_comb begin
        bad = {1'b0, haddr} >= (AddressWidth+1)'(MemBytes);
        bad = bad | (hsize > WORD);
        bad = bad | ((hsize == HALF) && haddr[0]);
        bad = bad | ((hsize == WORD) && (haddr[1:0] != 2'b00));
`ifdef AHB_SRAM_WRITE_PROTECT_EN
        bad = bad | (hwrite &&
              ({1'b0, haddr} < (AddressWidth+1)'(RomBytes)));
`endif
    end

    // Next state, counter and data-phase response
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        load      = 1'b0;
        unique case (state_q)
            S_WAIT: begin
                hreadyout = 1'b0;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_OKAY_DONE;
                end
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = S_ERR2;
            end
            S_ERR2: hresp = HRESP_ERROR;
            default: ;
        endcase
        if (hreadyout) begin
            load = hsel & hready & htrans[1];
            if (!load) begin
                state_d = S_IDLE;
            end else if (bad) begin
                state_d = S_ERR1;
            end else if (WaitStates == 0) begin
                state_d = S_OKAY_DONE;
            end else begin
                state_d = S_WAIT;
                cnt_d   = 4'(WaitStates);
            end
        end
    end

    // FSM and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the accepted address phase
    always_ff @(posedge clk) begin
        if (load) begin
            addr_q  <= haddr[AW-1:0];
            write_q <= hwrite;
            size_q  <= hsize;
        end
    end

    assign we      = (state_q == S_OKAY_DONE) && write_q && !rst;
    assign rd_done = (state_q == S_OKAY_DONE) && !write_q;

    ahb_sram_array #(
        .MemBytes(MemBytes)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .be   (lane_mask(addr_q[1:0], size_q)),
        .addr (addr_q[AW-1:2]),
        .wdata(hwdata),
        .rdata(rdata)
    );

    // Hold the last read word between read completions
    always_ff @(posedge clk) begin
        if (rst) begin
            hrdata_q <= '0;
        end else if (rd_done) begin
            hrdata_q <= rdata;
        end
    end

    assign hrdata = rd_done ? rdata : hrdata_q;

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Bench for ahb_sram_subordinate: three instances (0/1/3 wait states)
// behind a decoded bus, checked every cycle against a byte-array model.
module tb_ahb_sram_subordinate;

`ifdef AHB_SRAM_WRITE_PROTECT_EN
    localparam logic [31:0] B = 32'h400;
`else
    localparam logic [31:0] B = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrd [3];
    logic        hrs [3];
    logic        hro [3];
    logic        hs  [3];
    int          tgt;

    always #5 clk = ~clk;

    assign hready = hro[tgt];
    assign hs[0]  = hsel && (tgt == 0);
    assign hs[1]  = hsel && (tgt == 1);
    assign hs[2]  = hsel && (tgt == 2);

    ahb_sram_subordinate #(.WaitStates(0)) u_ws0 (
        .clk(clk), .rst(rst), .hsel(hs[0]), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata), .hready(hready),
        .hrdata(hrd[0]), .hresp(hrs[0]), .hreadyout(hro[0]));

    ahb_sram_subordinate #(.WaitStates(1)) u_ws1 (
        .clk(clk), .rst(rst), .hsel(hs[1]), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata), .hready(hready),
        .hrdata(hrd[1]), .hresp(hrs[1]), .hreadyout(hro[1]));

    ahb_sram_subordinate #(.WaitStates(3)) u_ws3 (
        .clk(clk), .rst(rst), .hsel(hs[2]), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata), .hready(hready),
        .hrdata(hrd[2]), .hresp(hrs[2]), .hreadyout(hro[2]));

    int          pass  = 0;
    int          total = 0;
    logic [7:0]  mdl [3][4096];
    logic [31:0] last_rd [3];
    logic [31:0] seen_rd [3];
    logic [31:0] prev_wd;
    bit          chk_en = 0;

    bit          dp_v = 0;
    int          dp_t;
    logic [31:0] dp_a;
    logic        dp_w;
    logic [2:0]  dp_sz;
    bit          dp_err;
    int          dp_low;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) pass++;
        else $display("FAIL %s: got %h required %h", nm, got, exp);
    endtask

    function automatic int ws_of(int t);
        return (t == 0) ? 0 : (t == 1) ? 1 : 3;
    endfunction

    function automatic logic [31:0] mword(int t, logic [31:0] a);
        int al;
        al = int'(a) & ~3;
        return {mdl[t][al+3], mdl[t][al+2], mdl[t][al+1], mdl[t][al]};
    endfunction

    function automatic bit is_err(logic [31:0] a, logic w, logic [2:0] sz);
        bit e;
        e = (a >= 32'd4096) || (sz > 3'd2);
        e = e || (sz == 3'd1 && a[0]);
        e = e || (sz == 3'd2 && a[1:0] != 2'b00);
`ifdef AHB_SRAM_WRITE_PROTECT_EN
        e = e || (w && a < 32'd1024);
`else
        e = e || (w && 1'b0);
`endif
        return e;
    endfunction

    // Per-cycle comparison of the selected data phase against the model
    always @(negedge clk) begin
        if (chk_en) begin
            bit rd_cmp;
            int exp_low;
            rd_cmp = dp_v && hro[dp_t] && !dp_w && !dp_err;
            if (dp_v) begin
                exp_low = dp_err ? 1 : ws_of(dp_t);
                if (!hro[dp_t]) begin
                    dp_low++;
                    chk("resp_stall", 32'(hrs[dp_t]), 32'(dp_err));
                    chk("stall_over", 32'(dp_low > exp_low), 0);
                end else begin
                    chk("stall_len", dp_low, exp_low);
                    chk("resp_done", 32'(hrs[dp_t]), 32'(dp_err));
                    if (rd_cmp) begin
                        chk("hrdata", hrd[dp_t], mword(dp_t, dp_a));
                        last_rd[dp_t] = mword(dp_t, dp_a);
                        seen_rd[dp_t] = hrd[dp_t];
                    end
                    if (dp_w && !dp_err && !rst) begin
                        int lo, nb, al;
                        lo = int'(dp_a[1:0]);
                        nb = 1 << dp_sz;
                        al = int'(dp_a) & ~3;
                        for (int k = 0; k < 4; k++)
                            if (k >= lo && k < lo + nb)
                                mdl[dp_t][al+k] = hwdata[8*k +: 8];
                    end
                    dp_v = 0;
                end
            end else begin
                chk("idle_ready", 32'(hro[tgt]), 1);
                chk("idle_resp", 32'(hrs[tgt]), 0);
            end
            for (int i = 0; i < 3; i++)
                if (!(rd_cmp && dp_t == i))
                    chk("hrdata_hold", hrd[i], last_rd[i]);
            if (rst) begin
                dp_v = 0;
                for (int i = 0; i < 3; i++) last_rd[i] = '0;
            end else if (hsel && hready && htrans[1]) begin
                dp_v   = 1;
                dp_t   = tgt;
                dp_a   = haddr;
                dp_w   = hwrite;
                dp_sz  = hsize;
                dp_err = is_err(haddr, hwrite, hsize);
                dp_low = 0;
            end
        end
    end

    task automatic wait_ready();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (hready) return;
        end
        total++;
        $display("FAIL ready_timeout: got hready 0 required 1");
    endtask

    task automatic beat(logic [1:0] tr, logic [31:0] a, logic w,
                        logic [2:0] sz, logic [31:0] wd);
        hsel   = 1'b1;
        htrans = tr;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        hwdata = prev_wd;
        wait_ready();
        @(posedge clk);
        #1;
        prev_wd = wd;
    endtask

    task automatic idle();
        hsel   = 1'b0;
        htrans = 2'd0;
        hwdata = prev_wd;
        wait_ready();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 4096; i++) mdl[t][i] = 8'h00;
            last_rd[t] = '0;
            seen_rd[t] = '0;
        end
        rst = 1; hsel = 0; haddr = 0; htrans = 0; hwrite = 0;
        hsize = 3'd2; hburst = 3'd0; hwdata = 0; prev_wd = 0; tgt = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", 32'(hro[i]), 1);
            chk("rst_resp", 32'(hrs[i]), 0);
            chk("rst_rdata", hrd[i], 0);
        end
        @(posedge clk); #1;

        tgt = 0;
        beat(2'd2, B + 32'h10, 1, 3'd2, 32'hDEADBEEF);
        beat(2'd2, B + 32'h10, 0, 3'd2, 0);
        idle();
        chk("lit_raw", seen_rd[0], 32'hDEADBEEF);

        tgt = 2;
        beat(2'd2, B, 1, 3'd2, 32'h0BADF00D);
        idle();
        beat(2'd2, B, 0, 3'd2, 0);
        idle();
        chk("lit_ws3", seen_rd[2], 32'h0BADF00D);

        tgt = 0;
        beat(2'd2, B + 32'h20, 1, 3'd2, 32'h11223344);
        beat(2'd2, B + 32'h21, 1, 3'd0, 32'h0000AA00);
        beat(2'd2, B + 32'h20, 0, 3'd2, 0);
        idle();
        chk("lit_byte", seen_rd[0], 32'h1122AA44);
        chk("lit_byte_mdl", mword(0, B + 32'h20), 32'h1122AA44);

        beat(2'd2, B, 1, 3'd2, 32'h33333333);
        beat(2'd2, B + 32'h3, 1, 3'd1, 32'hBEEF0000);
        beat(2'd2, 32'h1000, 0, 3'd2, 0);
        beat(2'd2, B, 0, 3'd2, 0);
        idle();
        chk("lit_err_keep", seen_rd[0], 32'h33333333);

        tgt = 1;
        hburst = 3'd5;
        for (int i = 0; i < 8; i++)
            beat(i == 0 ? 2'd2 : 2'd3, B + 32'h100 + 32'(4*i), 1, 3'd2,
                 32'hA0000000 + 32'(i) * 32'h01010101);
        for (int i = 0; i < 8; i++)
            beat(i == 0 ? 2'd2 : 2'd3, B + 32'h100 + 32'(4*i), 0, 3'd2, 0);
        idle();
        hburst = 3'd0;
        chk("lit_burst", seen_rd[1], 32'hA7070707);

        tgt = 2;
        beat(2'd2, B + 32'h40, 1, 3'd2, 32'h0);
        idle();
        beat(2'd2, B + 32'h40, 1, 3'd2, 32'hCAFEF00D);
        hsel = 0; htrans = 0; hwdata = prev_wd;
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        beat(2'd2, B + 32'h40, 0, 3'd2, 0);
        idle();
        chk("lit_rst_abandon", seen_rd[2], 32'h0);

`ifdef AHB_SRAM_WRITE_PROTECT_EN
        tgt = 0;
        beat(2'd2, 32'h0, 1, 3'd2, 32'h12345678);
        idle();
`endif
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule

// File: doc/ahb_sram_subordinate.md
Name: ahb_sram_subordinate

Overview:
- AHB-Lite subordinate backed by an internal flop-array memory: the responder end of an AHB manager data port, e.g. a DMA engine's master port.
- Lets DMA and other initiator DUTs run memory-to-memory traffic entirely in HDL, with no Renode round trip.
- Supports a programmable number of wait states and byte, halfword and word accesses.
- Returns the two-cycle AHB ERROR response on illegal accesses.

Parameters:
- AddressWidth, 32, width of haddr.
- DataWidth, 32, width of hwdata/hrdata; 32 only in this revision.
- MemBytes, 4096, memory size in bytes; power of two, multiple of 4.
- WaitStates, 0, hreadyout-low cycles inserted in every OKAY transfer (0..15).

Ports:
- clk  input  1  bus clock
- rst  input  1  synchronous active-high reset
- hsel  input  1  subordinate select
- haddr  input  AddressWidth  address-phase address
- htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  input  1  1=write
- hsize  input  3  0=byte, 1=half, 2=word
- hburst  input  3  ignored; each beat is decoded independently
- hwdata  input  DataWidth  data-phase write data
- hready  input  1  bus-wide ready (hreadyout looped back when single-subordinate)
- hrdata  output  DataWidth  read data
- hresp  output  1  0=OKAY, 1=ERROR
- hreadyout  output  1  data-phase completion

Behaviour:
- Reset (rst high at posedge): hreadyout=1, hresp=0, hrdata=0; FSM to IDLE; wait counter cleared.
  - Memory contents are not reset.
  - A transfer in flight when reset is asserted is abandoned; no write is committed.
- Address phase accepted when hsel & hready & htrans[1] at a posedge. The subordinate registers haddr, hwrite and hsize.
- IDLE/BUSY or hsel=0 with hready=1: the next cycle is zero-wait OKAY.
- Error check, on the registered address phase. Any one of these gives ERROR:
  - haddr >= MemBytes;
  - hsize > 2;
  - misalignment: half with addr[0]=1, word with addr[1:0]!=0.
- FSM states: IDLE, WAIT, OKAY_DONE, ERR1, ERR2.
- IDLE, legal transfer accepted:
  - WaitStates=0: go straight to OKAY_DONE; hreadyout=1 in the first data-phase cycle.
  - Otherwise go to WAIT with counter=WaitStates.
- WAIT: hreadyout=0, hresp=0; counter decrements each cycle; go to OKAY_DONE when the counter reaches 1.
- OKAY_DONE: hreadyout=1, hresp=0.
  - Write: byte lanes selected by addr[1:0]/hsize are written from hwdata at this posedge.
  - Read: hrdata = full aligned word at addr[..:2], all lanes driven.
  - A new address phase may be accepted in the same cycle (pipelined back-to-back).
- Illegal transfer accepted:
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
  - No memory update. An address phase presented during ERR2 is accepted normally.
- Read-after-write to the same word on consecutive beats returns the new data. The array is read combinationally from the registered address, and the write commits before the next data phase.
- hrdata holds its last value outside read completions.
- haddr bits above log2(MemBytes) count toward the range check only.

Optional Feature:
- Macro: AHB_SRAM_WRITE_PROTECT_EN.
- Defined:
  - Adds parameter RomBytes (default 1024).
  - Writes with addr < RomBytes get the ERROR response and leave memory unchanged; reads are unaffected.
- Undefined: the whole array is writable and the RomBytes parameter is absent.

Decomposition:
- Package ahb_pkg holds:
  - htrans_e (IDLE/BUSY/NONSEQ/SEQ) and hsize_e (BYTE/HALF/WORD);
  - HRESP_OKAY/HRESP_ERROR constants;
  - function lane_mask(addr[1:0], hsize) returning a 4-bit byte-enable.
- Sub-module ahb_sram_array: flop array with byte-enable write port and asynchronous read port, parameterised by MemBytes.

Test Plan:
- WaitStates=0: NONSEQ write word 0xDEADBEEF @0x10, then back-to-back read @0x10 -> read data phase hreadyout=1 first cycle, hrdata=0xDEADBEEF, hresp=0.
- WaitStates=3: single read @0x0 -> hreadyout low exactly 3 cycles, then high with OKAY.
- Byte write 0xAA @0x21 over word 0x11223344 @0x20 -> read @0x20 returns 0x1122AA44.
- Halfword write @0x03 (misaligned), and word read @MemBytes -> each gives ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1); memory unchanged.
- 8-beat INCR SEQ write burst 0x100..0x11C with WaitStates=1, then burst read -> data matches in order, 2 cycles per beat.
- rst asserted during the WAIT of a write @0x40 (old 0x0) -> outputs return to reset values next cycle; read @0x40 returns 0x0. With AHB_SRAM_WRITE_PROTECT_EN, a write @0x0 -> ERROR and the value is unchanged.
